// File: rtl/key_pkg.sv
// Shared state encoding and 50 MHz timing defaults for the push-button conditioning path.
package key_pkg;

    typedef enum logic [1:0] {
        KS_IDLE         = 2'd0,
        KS_PRESS_WAIT   = 2'd1,
        KS_HELD         = 2'd2,
        KS_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned KEY_N_KEYS_DEFAULT      = 4;
    localparam int unsigned KEY_DEBOUNCE_CYCLES_50M = 500000;
    localparam int unsigned KEY_REPEAT_DELAY_50M    = 25000000;
    localparam int unsigned KEY_REPEAT_PERIOD_50M   = 5000000;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and registered level/strobe outputs.
// Optional auto-repeat of the press strobe is built when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_50M,
    parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_50M,
    parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_50M
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_keyN,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned    CW       = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          w_pressed;
    key_state_t    r_state, w_stateNext;
    logic [CW-1:0] r_cnt, w_cntNext;
    logic          w_atLast;
    logic          r_level, w_levelNext;
    logic          r_press, w_pressNext;
    logic          r_release, w_releaseNext;
    logic          w_repeatStrobe;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~i_keyN};
        end
    end

    assign w_pressed = r_sync[1];
    assign w_atLast  = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= KS_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_level   <= w_levelNext;
            r_press   <= w_pressNext | w_repeatStrobe;
            r_release <= w_releaseNext;
        end
    end

    // The counter is cleared on every state entry, so it can never wrap.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_levelNext   = r_level;
        w_pressNext   = 1'b0;
        w_releaseNext = 1'b0;
        case (r_state)
            KS_IDLE: begin
                if (w_pressed) begin
                    w_stateNext = KS_PRESS_WAIT;
                    w_cntNext   = '0;
                end
            end
            KS_PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_stateNext = KS_IDLE;
                    w_cntNext   = '0;
                end else if (w_atLast) begin
                    w_stateNext = KS_HELD;
                    w_cntNext   = '0;
                    w_levelNext = 1'b1;
                    w_pressNext = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + 1'b1;
                end
            end
            KS_HELD: begin
                if (!w_pressed) begin
                    w_stateNext = KS_RELEASE_WAIT;
                    w_cntNext   = '0;
                end
            end
            KS_RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_stateNext = KS_HELD;
                    w_cntNext   = '0;
                end else if (w_atLast) begin
                    w_stateNext   = KS_IDLE;
                    w_cntNext     = '0;
                    w_levelNext   = 1'b0;
                    w_releaseNext = 1'b1;
                end else begin
                    w_cntNext     = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = KS_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rptCnt;
    logic [RPT_W-1:0] w_rptInc;
    logic             r_rptPeriodic;
    logic             w_accept;
    logic             w_heldStay;

    assign w_accept       = (r_state == KS_PRESS_WAIT) && w_pressed && w_atLast;
    assign w_heldStay     = (r_state == KS_HELD) && w_pressed;
    assign w_rptInc       = r_rptCnt + 1'b1;
    assign w_repeatStrobe = w_heldStay &&
                            (w_rptInc == (r_rptPeriodic ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));

    // First target is the initial delay, afterwards the repeat period; frozen outside HELD.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rptCnt      <= '0;
            r_rptPeriodic <= 1'b0;
        end else if (w_accept) begin
            r_rptCnt      <= '0;
            r_rptPeriodic <= 1'b0;
        end else if (w_heldStay) begin
            if (w_repeatStrobe) begin
                r_rptCnt      <= '0;
                r_rptPeriodic <= 1'b1;
            end else begin
                r_rptCnt      <= w_rptInc;
            end
        end
    end
`else
    assign w_repeatStrobe = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounced level plus press/release strobes for N_KEYS active-low push-buttons.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press strobes while a key is held.
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = KEY_N_KEYS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_50M,
    parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_50M,
    parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_50M
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clock   (CLOCK_50),
            .i_reset   (reset),
            .i_keyN    (key_n[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse: expectations are queued per clock edge and compared as edges pass.
module tb_key_debounce_pulse;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = DB + 3;

    typedef struct {
        int          cyc;
        logic [3:0]  level;
        logic [3:0]  press;
        logic [3:0]  rel;
        string       tag;
    } exp_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [NK-1:0] keyN;
    logic [NK-1:0] keyLevel;
    logic [NK-1:0] keyPress;
    logic [NK-1:0] keyRelease;

    exp_t expQ[$];
    int   edgeCount = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   t0;
    int   accEdge;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_debounce_pulse #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_n       (keyN),
        .key_level   (keyLevel),
        .key_press   (keyPress),
        .key_release (keyRelease)
    );

    task automatic expectAt(input int cyc, input logic [3:0] lvl, input logic [3:0] prs,
                            input logic [3:0] rel, input string tag);
        exp_t e;
        e.cyc   = cyc;
        e.level = lvl;
        e.press = prs;
        e.rel   = rel;
        e.tag   = tag;
        expQ.push_back(e);
    endtask

    task automatic expectRange(input int first, input int last, input logic [3:0] lvl,
                               input logic [3:0] prs, input logic [3:0] rel, input string tag);
        for (int c = first; c <= last; c++) expectAt(c, lvl, prs, rel, tag);
    endtask

    task automatic checkOutput();
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            exp_t e;
            e = expQ[i];
            if (e.cyc == edgeCount) begin
                checks++;
                assert (keyLevel === e.level) else begin
                    failures++;
                    $error("[TB] FAIL %s.level edge=%0d got=%b want=%b", e.tag, edgeCount, keyLevel, e.level);
                end
                checks++;
                assert (keyPress === e.press) else begin
                    failures++;
                    $error("[TB] FAIL %s.press edge=%0d got=%b want=%b", e.tag, edgeCount, keyPress, e.press);
                end
                checks++;
                assert (keyRelease === e.rel) else begin
                    failures++;
                    $error("[TB] FAIL %s.release edge=%0d got=%b want=%b", e.tag, edgeCount, keyRelease, e.rel);
                end
                expQ.delete(i);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            edgeCount++;
            #1;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        keyN = k;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at edge %0d", edgeCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        keyN  = 4'hF;
        #1;
        expectAt(0, 4'h0, 4'h0, 4'h0, "resetInit");
        checkOutput();
        expectRange(1, 2, 4'h0, 4'h0, 4'h0, "resetHold");
        tick(2);
        reset = 1'b0;

        // Clean press on key 0
        t0 = edgeCount;
        applyStimulus(4'b1110);
        expectRange(t0 + 1, t0 + LAT - 1, 4'h0, 4'h0, 4'h0, "pressWait");
        expectAt(t0 + LAT, 4'b0001, 4'b0001, 4'h0, "pressAccept");
        expectRange(t0 + LAT + 1, t0 + LAT + 3, 4'b0001, 4'h0, 4'h0, "pressHeld");
        tick(LAT + 3);

        // Async reset mid-cycle while key 0 is held, then re-qualification
        #3;
        reset = 1'b1;
        #1;
        expectAt(edgeCount, 4'h0, 4'h0, 4'h0, "asyncReset");
        checkOutput();
        expectAt(edgeCount + 1, 4'h0, 4'h0, 4'h0, "resetEdge");
        tick(1);
        reset = 1'b0;
        t0 = edgeCount;
        expectRange(t0 + 1, t0 + LAT - 1, 4'h0, 4'h0, 4'h0, "requalWait");
        expectAt(t0 + LAT, 4'b0001, 4'b0001, 4'h0, "requalAccept");
        expectAt(t0 + LAT + 1, 4'b0001, 4'h0, 4'h0, "requalHeld");
        tick(LAT + 1);

        // Clean release back to idle
        t0 = edgeCount;
        applyStimulus(4'hF);
        expectRange(t0 + 1, t0 + LAT - 1, 4'b0001, 4'h0, 4'h0, "relWait");
        expectAt(t0 + LAT, 4'h0, 4'h0, 4'b0001, "relAccept");
        expectAt(t0 + LAT + 1, 4'h0, 4'h0, 4'h0, "relIdle");
        tick(LAT + 1);

        // Bounce: low 3, high 1, then low and held
        t0 = edgeCount;
        expectRange(t0 + 1, t0 + 3 + LAT, 4'h0, 4'h0, 4'h0, "bounce");
        expectAt(t0 + 4 + LAT, 4'b0001, 4'b0001, 4'h0, "bounceAccept");
        expectAt(t0 + 5 + LAT, 4'b0001, 4'h0, 4'h0, "bounceHeld");
        applyStimulus(4'b1110);
        tick(3);
        applyStimulus(4'hF);
        tick(1);
        applyStimulus(4'b1110);
        tick(1 + LAT);

        // Release with a one-cycle low glitch
        t0 = edgeCount;
        expectRange(t0 + 1, t0 + 2 + LAT, 4'b0001, 4'h0, 4'h0, "glitchHeld");
        expectAt(t0 + 3 + LAT, 4'h0, 4'h0, 4'b0001, "glitchRelease");
        expectAt(t0 + 4 + LAT, 4'h0, 4'h0, 4'h0, "glitchIdle");
        applyStimulus(4'hF);
        tick(2);
        applyStimulus(4'b1110);
        tick(1);
        applyStimulus(4'hF);
        tick(1 + LAT);

        // All keys pressed and released together
        t0 = edgeCount;
        applyStimulus(4'h0);
        expectRange(t0 + 1, t0 + LAT - 1, 4'h0, 4'h0, 4'h0, "allPressWait");
        expectAt(t0 + LAT, 4'hF, 4'hF, 4'h0, "allPress");
        expectAt(t0 + LAT + 1, 4'hF, 4'h0, 4'h0, "allHeld");
        tick(LAT + 1);
        t0 = edgeCount;
        applyStimulus(4'hF);
        expectRange(t0 + 1, t0 + LAT - 1, 4'hF, 4'h0, 4'h0, "allRelWait");
        expectAt(t0 + LAT, 4'h0, 4'h0, 4'hF, "allRelease");
        expectAt(t0 + LAT + 1, 4'h0, 4'h0, 4'h0, "allIdle");
        tick(LAT + 1);

        // Long hold on key 1: repeat strobes only when auto-repeat is built
        t0      = edgeCount;
        accEdge = t0 + LAT;
        applyStimulus(4'b1101);
        expectRange(t0 + 1, accEdge - 1, 4'h0, 4'h0, 4'h0, "holdWait");
        for (int c = accEdge; c <= accEdge + 32; c++) begin
            logic strobe;
            strobe = (c == accEdge);
`ifdef KEY_AUTOREPEAT_EN
            if (c >= accEdge + RD && ((c - accEdge - RD) % RP) == 0) strobe = 1'b1;
`endif
            expectAt(c, 4'b0010, strobe ? 4'b0010 : 4'h0, 4'h0, "holdRepeat");
        end
        expectRange(accEdge + 33, accEdge + 36, 4'b0010, 4'h0, 4'h0, "holdRelWait");
        expectAt(accEdge + 37, 4'h0, 4'h0, 4'b0010, "holdRelease");
        expectAt(accEdge + 38, 4'h0, 4'h0, 4'h0, "holdIdle");
        tick(LAT + 30);
        applyStimulus(4'hF);
        tick(8);

        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL pendingExpectations got=%0d want=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
